// File: rtl/centroid_pkg.sv
// Shared widths, FSM states and datapath types for centroid_calc.
// Define CENTROID_WEIGHTED_EN for an intensity-weighted centroid.
package centroid_pkg;

`ifdef CENTROID_WEIGHTED_EN
   localparam int W_EXTRA = 4;
`else
   localparam int W_EXTRA = 0;
`endif

   function automatic int sum_w(input int img_w, input int roi_h);
      return $clog2(img_w * img_w * roi_h) + W_EXTRA;
   endfunction

   function automatic int cnt_w(input int img_w, input int roi_h);
      return $clog2(img_w * roi_h + 1) + W_EXTRA;
   endfunction

   typedef enum logic [1:0] {IDLE, DIV, DONE, LOST} state_t;

   localparam int SUM_W_DEF = sum_w(640, 60);
   localparam int CNT_W_DEF = cnt_w(640, 60);

   typedef logic [SUM_W_DEF-1:0] sum_t;
   typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/centroid_calc_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock.
// start loads operands; done pulses once when quo is final.
module seq_divider #(
   parameter int N_W = 25,
   parameter int D_W = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N_W-1:0] num,
   input  logic [D_W-1:0] den,
   output logic           busy,
   output logic           done,
   output logic [N_W-1:0] quo
);

   localparam int C_W = $clog2(N_W + 1);

   logic [D_W-1:0] rem;
   logic [D_W-1:0] den_q;
   logic [C_W-1:0] left;
   logic [D_W:0]   trial;
   logic           ge;

   assign trial = {rem, quo[N_W-1]};
   assign ge    = trial >= {1'b0, den_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem   <= '0;
         den_q <= '0;
         quo   <= '0;
         left  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem   <= '0;
            den_q <= den;
            quo   <= num;
            left  <= C_W'(N_W);
            busy  <= 1'b1;
         end else if (busy) begin
            // remainder < den always fits in D_W bits
            rem  <= ge ? trial[D_W-1:0] - den_q : trial[D_W-1:0];
            quo  <= {quo[N_W-2:0], ge};
            left <= left - C_W'(1);
            if (left == C_W'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/centroid_calc.sv
// Per-frame horizontal centroid of edge pixels in a bottom-of-frame ROI.
// Define CENTROID_WEIGHTED_EN for an intensity-weighted mean.
module centroid_calc
   import centroid_pkg::*;
#(
   parameter int IMG_W      = 640,
   parameter int IMG_H      = 480,
   parameter int ROI_HEIGHT = 60,
   parameter int THRESHOLD  = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [3:0]               pixel_in,
   input  logic                     in_ready,
   output logic [$clog2(IMG_W):0]   centroid_x,
   output logic                     line_valid,
   output logic                     line_lost
);

   localparam int X_W   = $clog2(IMG_W) + 1;
   localparam int Y_W   = $clog2(IMG_H);
   localparam int SUM_W = sum_w(IMG_W, ROI_HEIGHT);
   localparam int CNT_W = cnt_w(IMG_W, ROI_HEIGHT);

   logic [X_W-1:0]   x;
   logic [Y_W-1:0]   y;
   logic [SUM_W-1:0] sum_x, sum_inc, sum_nxt;
   logic [CNT_W-1:0] cnt, cnt_inc, cnt_nxt;
   logic [SUM_W-1:0] quo;
   logic [X_W-1:0]   cx_sat;
   logic             last_x, last_y, eof, in_roi, hit;
   logic             start, lost_go, div_busy, div_done;
   state_t           state, state_nxt;

   assign last_x = x == X_W'(IMG_W - 1);
   assign last_y = y == Y_W'(IMG_H - 1);
   assign eof    = in_ready & last_x & last_y;
   assign in_roi = y >= Y_W'(IMG_H - ROI_HEIGHT);
   assign hit    = in_ready & in_roi & (pixel_in > 4'(THRESHOLD));

`ifdef CENTROID_WEIGHTED_EN
   assign sum_inc = SUM_W'(x) * SUM_W'(pixel_in);
   assign cnt_inc = CNT_W'(pixel_in);
`else
   assign sum_inc = SUM_W'(x);
   assign cnt_inc = CNT_W'(1);
`endif

   // next-sum includes the EOF pixel so the snapshot is complete
   assign sum_nxt = sum_x + (hit ? sum_inc : '0);
   assign cnt_nxt = cnt + (hit ? cnt_inc : '0);

   assign start   = eof & (state == IDLE) & (cnt_nxt != '0);
   assign lost_go = eof & (state == IDLE) & (cnt_nxt == '0);

   assign cx_sat = (|quo[SUM_W-1:X_W]) ? '1 : quo[X_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x     <= '0;
         y     <= '0;
         sum_x <= '0;
         cnt   <= '0;
      end else if (in_ready) begin
         if (last_x) begin
            x <= '0;
            y <= last_y ? '0 : y + Y_W'(1);
         end else begin
            x <= x + X_W'(1);
         end
         sum_x <= eof ? '0 : sum_nxt;
         cnt   <= eof ? '0 : cnt_nxt;
      end
   end

   seq_divider #(
      .N_W (SUM_W),
      .D_W (CNT_W)
   ) u_div (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .num   (sum_nxt),
      .den   (cnt_nxt),
      .busy  (div_busy),
      .done  (div_done),
      .quo   (quo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         centroid_x <= '0;
         line_lost  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == DIV && div_done) begin
            centroid_x <= cx_sat;
            line_lost  <= 1'b0;
         end else if (lost_go) begin
            line_lost <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      line_valid = 1'b0;
      unique case (state)
         IDLE: begin
            if (start)        state_nxt = DIV;
            else if (lost_go) state_nxt = LOST;
         end
         DIV: begin
            if (div_done || !div_busy && !start) state_nxt = div_done ? DONE : IDLE;
         end
         DONE: begin
            line_valid = 1'b1;
            state_nxt  = IDLE;
         end
         LOST: begin
            line_valid = 1'b1;
            state_nxt  = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_centroid_calc.sv
// Directed bench for centroid_calc on a shortened 640x6 frame, ROI = 2 rows.
// Two instances share stimulus: THRESHOLD 0 and THRESHOLD 7.
module tb_centroid_calc;

   localparam int W  = 640;
   localparam int H  = 6;
   localparam int R  = 2;
   localparam int Y0 = H - R;
   // SUM_W = clog2(640*640*2) = 20, so result lands 22 cycles after EOF
   localparam int D_DONE = 22;
   localparam int D_LOST = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_ready;
   logic [3:0]  pixel_in;
   logic [10:0] cx0, cx7;
   logic        lv0, lv7, ll0, ll7;

   int cyc = 0;
   int np0 = 0, np7 = 0, pc0 = 0, pc7 = 0;
   int eof_cyc = 0;
   int n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   centroid_calc #(
      .IMG_W(W), .IMG_H(H), .ROI_HEIGHT(R), .THRESHOLD(0)
   ) dut0 (
      .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_ready(in_ready),
      .centroid_x(cx0), .line_valid(lv0), .line_lost(ll0)
   );

   centroid_calc #(
      .IMG_W(W), .IMG_H(H), .ROI_HEIGHT(R), .THRESHOLD(7)
   ) dut7 (
      .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_ready(in_ready),
      .centroid_x(cx7), .line_valid(lv7), .line_lost(ll7)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (lv0) begin
         np0 <= np0 + 1;
         pc0 <= cyc;
      end
      if (lv7) begin
         np7 <= np7 + 1;
         pc7 <= cyc;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic logic [3:0] pix(input int kind, input int x, input int y);
      logic roi;
      roi = (y >= Y0);
      case (kind)
         1: return (roi && x == 100) ? 4'hF : 4'h0;
         2: return (roi && (x == 200 || x == 301)) ? 4'h1 : 4'h0;
         3: return (!roi && x == 600) ? 4'hF : 4'h0;
         4: return !roi ? 4'h0 : (x == 50) ? 4'h7 : (x == 500) ? 4'h8 : 4'h0;
         5: return (roi && x == 320) ? 4'hF : 4'h0;
         default: return 4'h0;
      endcase
   endfunction

   // stop_beat < 0 drives the whole frame
   task automatic drive_frame(input int kind, input bit gaps, input int stop_beat);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            if (y * W + x == stop_beat) begin
               in_ready = 1'b0;
               pixel_in = 4'h0;
               return;
            end
            while (gaps && $urandom_range(0, 1) == 1) begin
               in_ready = 1'b0;
               pixel_in = 4'($urandom);
               @(posedge clk);
               #1;
            end
            in_ready = 1'b1;
            pixel_in = pix(kind, x, y);
            @(posedge clk);
            #1;
         end
      end
      in_ready = 1'b0;
      pixel_in = 4'h0;
      eof_cyc  = cyc;
   endtask

   task automatic frame(input string tag, input int kind, input bit gaps,
                        input int e_cx0, input int e_l0, input int e_d0,
                        input int e_cx7, input int e_l7, input int e_d7);
      int b0, b7;
      b0 = np0;
      b7 = np7;
      drive_frame(kind, gaps, -1);
      repeat (40) @(posedge clk);
      #1;
      chk({tag, " pulses0"}, np0 - b0, 1);
      chk({tag, " cx0"}, int'(cx0), e_cx0);
      chk({tag, " lost0"}, int'(ll0), e_l0);
      chk({tag, " delay0"}, pc0 - eof_cyc + 1, e_d0);
      chk({tag, " pulses7"}, np7 - b7, 1);
      chk({tag, " cx7"}, int'(cx7), e_cx7);
      chk({tag, " lost7"}, int'(ll7), e_l7);
      chk({tag, " delay7"}, pc7 - eof_cyc + 1, e_d7);
   endtask

   task automatic pulse_reset(input string tag);
      #3 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk({tag, " rst cx0"}, int'(cx0), 0);
      chk({tag, " rst lost0"}, int'(ll0), 0);
      chk({tag, " rst cx7"}, int'(cx7), 0);
      chk({tag, " rst lv0"}, int'(lv0), 0);
      rst = 1'b0;
   endtask

   initial begin
      int b0, b7;
      rst      = 1'b1;
      in_ready = 1'b0;
      pixel_in = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset cx", int'(cx0), 0);
      chk("reset valid", int'(lv0), 0);
      chk("reset lost", int'(ll0), 0);
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("idle cx", int'(cx0), 0);
      chk("idle lost", int'(ll0), 0);
      chk("idle pulses", np0 + np7, 0);

      frame("zero",   0, 1'b0,   0, 1, D_LOST,   0, 1, D_LOST);
      frame("pair",   2, 1'b0, 250, 0, D_DONE,   0, 1, D_LOST);
      frame("x100",   1, 1'b0, 100, 0, D_DONE, 100, 0, D_DONE);
      frame("noroi",  3, 1'b0, 100, 1, D_LOST, 100, 1, D_LOST);
      frame("x100b",  1, 1'b0, 100, 0, D_DONE, 100, 0, D_DONE);
      frame("thr",    4, 1'b0, 275, 0, D_DONE, 500, 0, D_DONE);
      frame("thrgap", 4, 1'b1, 275, 0, D_DONE, 500, 0, D_DONE);

      // reset while the divider is running: no pulse may follow
      b0 = np0;
      b7 = np7;
      drive_frame(5, 1'b0, -1);
      repeat (8) @(posedge clk);
      pulse_reset("middiv");
      repeat (40) @(posedge clk);
      #1;
      chk("middiv pulses0", np0 - b0, 0);
      chk("middiv pulses7", np7 - b7, 0);

      // reset part-way through an ROI row, then a clean frame
      b0 = np0;
      drive_frame(5, 1'b0, Y0 * W + 400);
      pulse_reset("midframe");
      repeat (10) @(posedge clk);
      #1;
      chk("midframe pulses0", np0 - b0, 0);
      frame("x320",   5, 1'b0, 320, 0, D_DONE, 320, 0, D_DONE);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
